// File: rtl/core_pkg.sv
// Shared types and constants for the accumulator core's control interface.
// Holds the fetch FSM state type, decoder opcodes and instruction field layout.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_W   = 9;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned OPND_W    = 4;
  localparam int unsigned TYPE_BIT  = 8;
  localparam int unsigned OP_MSB    = 7;
  localparam int unsigned OP_LSB    = 4;
  localparam int unsigned OPND_MSB  = 3;
  localparam int unsigned OPND_LSB  = 0;
  localparam int unsigned TBL_DEPTH = 16;
  localparam int unsigned TBL_AW    = 4;

  localparam logic [OP_W-1:0] OP_BT   = 4'd7;
  localparam logic [OP_W-1:0] OP_BF   = 4'd8;
  localparam logic [OP_W-1:0] OP_HALT = 4'd15;

  // bt branches on a set condition bit, bf on a clear one
  function automatic logic branchTaken(input logic lookUp,
                                       input logic [OP_W-1:0] op,
                                       input logic cond);
    return lookUp && (((op == OP_BT) && cond) || ((op == OP_BF) && !cond));
  endfunction

endpackage

// File: rtl/branch_lut.sv
// 16-entry branch target table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; software loads them before use.
module branch_lut
  import core_pkg::*;
#(
  parameter int unsigned PC_W = 10
) (
  input  logic              Clk,
  input  logic              We,
  input  logic [TBL_AW-1:0] WrAddr,
  input  logic [PC_W-1:0]   WrData,
  input  logic [TBL_AW-1:0] RdAddr,
  output logic [PC_W-1:0]   RdData
);

  logic [PC_W-1:0] entries [TBL_DEPTH];

  always_ff @(posedge Clk) begin
    if (We) begin
      entries[WrAddr] <= WrData;
    end
  end

  assign RdData = entries[RdAddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/issue for the accumulator core: PC, field split, branch and halt
// handling, Start/Ack handshake and saturating RUN-cycle counter.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned START_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [INSTR_W-1:0]  Instr,
  input  logic                Halt,
  input  logic                LookUp,
  input  logic                Cond,
  input  logic                TblWe,
  input  logic [TBL_AW-1:0]   TblAddr,
  input  logic [PC_W-1:0]     TblData,
  output logic [PC_W-1:0]     PC,
  output logic                TypeBit,
  output logic [OP_W-1:0]     OP,
  output logic [OPND_W-1:0]   Operand,
  output logic                InstrValid,
  output logic                Ack,
  output logic [CNT_W-1:0]    CycleCount
);

  localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);

  fetch_state_t     state;
  fetch_state_t     stateNext;
  logic [PC_W-1:0]  pcReg;
  logic [PC_W-1:0]  pcNext;
  logic [CNT_W-1:0] cntReg;
  logic [CNT_W-1:0] cntNext;
  logic             ackReg;
  logic             validReg;
  logic             tblWeC;
  logic [PC_W-1:0]  tblTarget;

  // Field split is purely combinational; InstrValid qualifies it downstream
  assign TypeBit = Instr[TYPE_BIT];
  assign OP      = Instr[OP_MSB:OP_LSB];
  assign Operand = Instr[OPND_MSB:OPND_LSB];

  // Table is frozen while a program runs so targets cannot shift under it
  assign tblWeC = TblWe && (state != RUN);

  branch_lut #(
    .PC_W (PC_W)
  ) uLut (
    .Clk    (Clk),
    .We     (tblWeC),
    .WrAddr (TblAddr),
    .WrData (TblData),
    .RdAddr (Operand),
    .RdData (tblTarget)
  );

  // Next-state, next-PC and counter update
  always_comb begin
    stateNext = state;
    pcNext    = pcReg;
    cntNext   = cntReg;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          stateNext = RUN;
          pcNext    = START_PC_V;
          cntNext   = '0;
        end
      end
      RUN: begin
        if (cntReg != {CNT_W{1'b1}}) begin
          cntNext = cntReg + CNT_W'(1);
        end
        if (Halt) begin
          stateNext = DONE;
        end else if (branchTaken(LookUp, OP, Cond)) begin
          pcNext = tblTarget;
        end else begin
          pcNext = pcReg + PC_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        pcNext    = START_PC_V;
        cntNext   = '0;
      end
    endcase
  end

  // Ack and InstrValid are registered from the next state so they line up with it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      pcReg    <= START_PC_V;
      cntReg   <= '0;
      ackReg   <= 1'b0;
      validReg <= 1'b0;
    end else begin
      state    <= stateNext;
      pcReg    <= pcNext;
      cntReg   <= cntNext;
      ackReg   <= (stateNext == DONE);
      validReg <= (stateNext == RUN);
    end
  end

  assign PC         = pcReg;
  assign CycleCount = cntReg;
  assign Ack        = ackReg;
  assign InstrValid = validReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM and decoder modelled here, outputs checked each cycle
// against a cycle-level reference of the fetch rules plus directed spot checks.
module tb_fetch_unit;

  localparam int unsigned PW   = 10;
  localparam int unsigned CW   = 16;
  localparam int unsigned PMOD = 1024;
  localparam int unsigned CMAX = 65535;

  localparam logic [8:0] I_ADD  = {1'b1, 4'd1, 4'd2};
  localparam logic [8:0] I_HALT = {1'b1, 4'd15, 4'd0};

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic [8:0]    Instr;
  logic          Halt;
  logic          LookUp;
  logic          Cond;
  logic          TblWe;
  logic [3:0]    TblAddr;
  logic [PW-1:0] TblData;
  logic [PW-1:0] PC;
  logic          TypeBit;
  logic [3:0]    OP;
  logic [3:0]    Operand;
  logic          InstrValid;
  logic          Ack;
  logic [CW-1:0] CycleCount;

  logic [8:0] rom [PMOD];

  int unsigned nVec = 0;
  int unsigned nErr = 0;

  // Reference state: 0 idle, 1 run, 2 done
  int unsigned mState;
  int unsigned mPc;
  int unsigned mCnt;
  int unsigned mTbl [16];

  fetch_unit #(.PC_W(PW), .START_PC(0), .CNT_W(CW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Instr      (Instr),
    .Halt       (Halt),
    .LookUp     (LookUp),
    .Cond       (Cond),
    .TblWe      (TblWe),
    .TblAddr    (TblAddr),
    .TblData    (TblData),
    .PC         (PC),
    .TypeBit    (TypeBit),
    .OP         (OP),
    .Operand    (Operand),
    .InstrValid (InstrValid),
    .Ack        (Ack),
    .CycleCount (CycleCount)
  );

  // Asynchronous ROM and a minimal control decoder
  assign Instr  = rom[PC];
  assign Halt   = Instr[8] && (Instr[7:4] == 4'd15);
  assign LookUp = Instr[8] && ((Instr[7:4] == 4'd7) || (Instr[7:4] == 4'd8));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [8:0] mkBranch(input int unsigned op, input int unsigned idx);
    return {1'b1, 4'(op), 4'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the reference from the current inputs, then compare
  task automatic step();
    int unsigned instr, tb, op, opnd, nS, nP, nC;
    bit halt, taken;
    instr = int'(rom[mPc]);
    tb    = (instr >> 8) & 1;
    op    = (instr >> 4) & 15;
    opnd  = instr & 15;
    halt  = (tb == 1) && (op == 15);
    taken = (tb == 1) && (((op == 7) && Cond) || ((op == 8) && !Cond));
    nS = mState; nP = mPc; nC = mCnt;
    if (Reset) begin
      nS = 0; nP = 0; nC = 0;
    end else if (mState == 1) begin
      nC = (mCnt == CMAX) ? mCnt : mCnt + 1;
      if (halt) nS = 2;
      else if (taken) nP = mTbl[opnd];
      else nP = (mPc + 1) % PMOD;
    end else if (Start) begin
      nS = 1; nP = 0; nC = 0;
    end
    if (TblWe && (mState != 1)) mTbl[TblAddr] = int'(TblData);
    @(posedge Clk);
    #1;
    mState = nS; mPc = nP; mCnt = nC;
    instr = int'(rom[mPc]);
    chk("pc", 32'(PC), 32'(mPc));
    chk("ack", 32'(Ack), 32'(mState == 2));
    chk("valid", 32'(InstrValid), 32'(mState == 1));
    chk("count", 32'(CycleCount), 32'(mCnt));
    chk("fields", {23'd0, TypeBit, OP, Operand}, 32'(instr));
  endtask

  task automatic runToDone(input string tag, input int unsigned budget);
    int unsigned n = 0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    while ((mState != 2) && (n < budget)) begin
      step();
      n++;
    end
    chk(tag, 32'(mState == 2), 32'd1);
  endtask

  initial begin
    mState = 0; mPc = 0; mCnt = 0;
    for (int i = 0; i < 16; i++) mTbl[i] = 0;
    for (int i = 0; i < int'(PMOD); i++) rom[i] = I_ADD;
    Reset = 1'b1; Start = 1'b0; Cond = 1'b0;
    TblWe = 1'b0; TblAddr = '0; TblData = '0;
    step();
    step();
    Reset = 1'b0;
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_count", 32'(CycleCount), 32'd0);

    // Load every table entry in IDLE; entry 5 is the directed branch target
    for (int i = 0; i < 16; i++) begin
      TblWe = 1'b1; TblAddr = 4'(i);
      TblData = (i == 5) ? 10'h040 : 10'($urandom_range(0, PMOD - 1));
      step();
    end
    TblWe = 1'b0;

    // add, add, halt
    rom[2] = I_HALT;
    runToDone("prog1_done", 10);
    chk("prog1_pc", 32'(PC), 32'd2);
    chk("prog1_ack", 32'(Ack), 32'd1);
    chk("prog1_count", 32'(CycleCount), 32'd3);
    step();
    chk("prog1_hold", 32'(PC), 32'd2);

    // bt / bf taken and not taken
    rom[10'h040] = I_HALT;
    rom[1] = mkBranch(7, 5); Cond = 1'b1;
    runToDone("bt_taken_done", 10);
    chk("bt_taken_pc", 32'(PC), 32'h040);
    Cond = 1'b0;
    runToDone("bt_fall_done", 10);
    chk("bt_fall_pc", 32'(PC), 32'd2);
    rom[1] = mkBranch(8, 5); Cond = 1'b0;
    runToDone("bf_taken_done", 10);
    chk("bf_taken_pc", 32'(PC), 32'h040);
    Cond = 1'b1;
    runToDone("bf_fall_done", 10);
    chk("bf_fall_pc", 32'(PC), 32'd2);

    // Table write and Start in the same IDLE cycle: first instruction uses new entry
    Reset = 1'b1; step(); Reset = 1'b0;
    rom[0] = mkBranch(7, 3); rom[10'h100] = I_HALT; Cond = 1'b1;
    TblWe = 1'b1; TblAddr = 4'd3; TblData = 10'h100; Start = 1'b1;
    step();
    TblWe = 1'b0; Start = 1'b0;
    step();
    chk("wr_start_pc", 32'(PC), 32'h100);
    step();
    chk("wr_start_done", 32'(Ack), 32'd1);

    // Wrap past 0x3FF with a dropped table write mid-run, then reset mid-run
    for (int i = 0; i < int'(PMOD); i++) rom[i] = I_ADD;
    Start = 1'b1; step(); Start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    TblWe = 1'b1; TblAddr = 4'd5; TblData = 10'h3AA; step(); TblWe = 1'b0;
    for (int i = 0; (i < 1100) && (mPc != PMOD - 1); i++) step();
    chk("pre_wrap_pc", 32'(PC), 32'h3FF);
    step();
    chk("wrap_pc", 32'(PC), 32'h000);
    for (int i = 0; (i < 40) && (mPc != 32'h12); i++) step();
    chk("pre_rst_pc", 32'(PC), 32'h012);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("mid_rst_pc", 32'(PC), 32'd0);
    chk("mid_rst_ack", 32'(Ack), 32'd0);
    chk("mid_rst_valid", 32'(InstrValid), 32'd0);
    chk("mid_rst_count", 32'(CycleCount), 32'd0);
    rom[1] = mkBranch(7, 5); rom[10'h040] = I_HALT; Cond = 1'b1;
    runToDone("retain_done", 10);
    chk("retain_pc", 32'(PC), 32'h040);

    // Restart from DONE and run long enough to saturate the counter
    for (int i = 0; i < int'(PMOD); i++) rom[i] = I_ADD;
    Start = 1'b1; step(); Start = 1'b0;
    chk("restart_ack", 32'(Ack), 32'd0);
    chk("restart_pc", 32'(PC), 32'd0);
    chk("restart_count", 32'(CycleCount), 32'd0);
    for (int i = 0; i < 65600; i++) step();
    chk("sat_count", 32'(CycleCount), 32'hFFFF);

    // Randomized programs, conditions, table writes, starts and resets
    for (int i = 0; i < int'(PMOD); i++) rom[i] = 9'($urandom_range(0, 511));
    for (int i = 0; i < 3000; i++) begin
      Reset   = ($urandom_range(0, 199) == 0);
      Start   = ($urandom_range(0, 7) == 0);
      Cond    = 1'($urandom_range(0, 1));
      TblWe   = !Reset && ($urandom_range(0, 3) == 0);
      TblAddr = 4'($urandom_range(0, 15));
      TblData = 10'($urandom_range(0, PMOD - 1));
      step();
    end
    Reset = 1'b0; Start = 1'b0; TblWe = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
